// File: rtl/relay_pkg.sv
// Shared definitions for the relay hold driver.
//   relay_state_t : driver FSM states (OFF, ON_HOLD, ON, OFF_HOLD)
//   RELAY_CNT_W   : default width of the hold and on-time counters
package relay_pkg;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_ON_HOLD  = 2'd1,
    ST_ON       = 2'd2,
    ST_OFF_HOLD = 2'd3
  } relay_state_t;

  localparam int RELAY_CNT_W = 10;

endpackage

// File: rtl/relay_hold_timer.sv
// Loadable down-counter that times a minimum-hold interval.
//   clk, reset : clock, asynchronous active-high reset
//   load       : load load_val into the counter (wins over counting)
//   load_val   : hold length minus one
//   done       : count is zero, i.e. this is the last cycle of the hold
// Loading N-1 on the edge that enters a hold makes done rise in the N-th
// cycle of that hold, so the hold lasts exactly N cycles.
module relay_hold_timer
  import relay_pkg::*;
#(
  parameter int CNT_W = RELAY_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/relay_hold_driver.sv
// Relay/valve driver enforcing minimum on and off times.
//   clk, reset : clock, asynchronous active-high reset
//   on_req     : single-cycle request to energise the relay
//   off_req    : single-cycle request to de-energise (wins over on_req)
//   relay_out  : registered drive, 1 = energised
//   locked     : a minimum-hold interval is running
//   ack        : one-cycle pulse in the first cycle relay_out holds a new value
//   fault      : sticky max-on-time trip flag
// Optional feature: define RELAY_MAX_ON_EN to build the max-on watchdog;
// without it the on-time counter is absent and fault is tied low.
module relay_hold_driver
  import relay_pkg::*;
#(
  parameter int MIN_ON_CYC  = 30,
  parameter int MIN_OFF_CYC = 30,
  parameter int MAX_ON_CYC  = 1000,
  parameter int CNT_W       = RELAY_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic on_req,
  input  logic off_req,
  output logic relay_out,
  output logic locked,
  output logic ack,
  output logic fault
);

  // Every cycle count must be non-zero and fit in the counters.
  if (MIN_ON_CYC < 1 || MIN_ON_CYC >= (1 << CNT_W) ||
      MIN_OFF_CYC < 1 || MIN_OFF_CYC >= (1 << CNT_W) ||
      MAX_ON_CYC < 1 || MAX_ON_CYC >= (1 << CNT_W)) begin : g_param_check
    $error("relay_hold_driver: cycle parameter out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(MIN_ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(MIN_OFF_CYC - 1);

  relay_state_t     state, state_nxt;
  logic             relay_nxt, ack_nxt;
  logic             desired, desired_req, desired_nxt;
  logic             flip;
  logic             timer_load, timer_done;
  logic [CNT_W-1:0] timer_val;
  logic             trip;

  relay_hold_timer #(.CNT_W(CNT_W)) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    desired_req = off_req ? 1'b0 : (on_req ? 1'b1 : desired);
    desired_nxt = desired_req;
    state_nxt   = state;
    relay_nxt   = relay_out;
    ack_nxt     = 1'b0;
    timer_load  = 1'b0;
    timer_val   = OFF_LOAD;
    flip        = 1'b0;

    // Stable states act on a request at once; hold states only look at the
    // desired value on their last cycle and otherwise settle quietly.
    case (state)
      ST_OFF, ST_ON: flip = (desired_req != relay_out);
      ST_ON_HOLD: begin
        if (timer_done) begin
          flip = !desired_req;
          if (desired_req) state_nxt = ST_ON;
        end
      end
      ST_OFF_HOLD: begin
        if (timer_done) begin
          flip = desired_req;
          if (!desired_req) state_nxt = ST_OFF;
        end
      end
      default: flip = 1'b0;
    endcase

    // A toggle (requested or forced by the watchdog) always starts the
    // opposite hold on the same edge. relay_out is 1 only in ON/ON_HOLD, so
    // inverting it gives the new drive level.
    if (flip || trip) begin
      relay_nxt  = trip ? 1'b0 : ~relay_out;
      ack_nxt    = 1'b1;
      timer_load = 1'b1;
      state_nxt  = relay_nxt ? ST_ON_HOLD : ST_OFF_HOLD;
      timer_val  = relay_nxt ? ON_LOAD : OFF_LOAD;
    end
    if (trip) desired_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_OFF;
      relay_out <= 1'b0;
      ack       <= 1'b0;
      desired   <= 1'b0;
    end else begin
      state     <= state_nxt;
      relay_out <= relay_nxt;
      ack       <= ack_nxt;
      desired   <= desired_nxt;
    end
  end

  assign locked = (state == ST_ON_HOLD) || (state == ST_OFF_HOLD);

`ifdef RELAY_MAX_ON_EN
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_ON_CYC - 1);

  logic [CNT_W-1:0] on_cnt;
  logic             fault_q;

  // on_cnt holds the number of energised cycles before the current one, so
  // reaching MAX_LAST while energised means this is the MAX_ON_CYC-th cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      on_cnt  <= '0;
      fault_q <= 1'b0;
    end else begin
      on_cnt <= relay_out ? on_cnt + 1'b1 : '0;
      if (trip) fault_q <= 1'b1;
    end
  end

  assign trip  = relay_out && (on_cnt == MAX_LAST);
  assign fault = fault_q;
`else
  assign trip  = 1'b0;
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_relay_hold_driver.sv
// Self-checking bench for relay_hold_driver (MIN_ON/OFF = 30, MAX_ON = 100).
// Cycle 0 is the first cycle after reset is released; a request driven in
// cycle c is sampled on the edge ending cycle c. Expected outputs for each
// cycle are queued as the stimulus for that cycle is driven and popped once
// the DUT has produced them.
`timescale 1ns/1ps
module tb_relay_hold_driver;

  logic clk = 1'b0;
  logic reset, on_req, off_req;
  logic relay_out, locked, ack, fault;

  typedef struct packed {
    logic relay;
    logic locked;
    logic ack;
    logic fault;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

`ifdef RELAY_MAX_ON_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  always #5 clk = ~clk;

  relay_hold_driver #(
    .MIN_ON_CYC  (30),
    .MIN_OFF_CYC (30),
    .MAX_ON_CYC  (100),
    .CNT_W       (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .on_req    (on_req),
    .off_req   (off_req),
    .relay_out (relay_out),
    .locked    (locked),
    .ack       (ack),
    .fault     (fault)
  );

  function automatic exp_t mk(input bit r, input bit l, input bit a, input bit f);
    return {r, l, a, f};
  endfunction

  // Drive one cycle of requests, then move to #1 after the next edge.
  task automatic drive(input bit on, input bit off);
    on_req  = on;
    off_req = off;
    @(posedge clk);
    #1;
    on_req  = 1'b0;
    off_req = 1'b0;
  endtask

  // Reset for one edge, release; returns at the start of cycle 0.
  task automatic start();
    exp_q.delete();
    reset   = 1'b1;
    on_req  = 1'b0;
    off_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    reset   = 1'b1;
    on_req  = 1'b0;
    off_req = 1'b0;
    #1;
    e = mk(0, 0, 0, 0);
    vectors++;
    if ({relay_out, locked, ack, fault} !== e) begin
      miscompares++;
      $display("FAIL reset_async: got %b need %b", {relay_out, locked, ack, fault}, e);
    end
    // Requests are ignored while reset is held.
    drive(1'b1, 1'b0);
    vectors++;
    if ({relay_out, locked, ack, fault} !== e) begin
      miscompares++;
      $display("FAIL reset_held: got %b need %b", {relay_out, locked, ack, fault}, e);
    end
    reset = 1'b0;
  endtask

  task automatic test_on_hold();
    exp_t e;
    int t;
    start();
    for (int c = 0; c < 40; c++) begin
      t = c + 1;
      exp_q.push_back(mk(t >= 6, t >= 6 && t <= 35, t == 6, 1'b0));
      drive(c == 5, 1'b0);
      e = exp_q.pop_front();
      vectors++;
      if ({relay_out, locked, ack, fault} !== e) begin
        miscompares++;
        $display("FAIL on_hold cyc %0d: got %b need %b", t, {relay_out, locked, ack, fault}, e);
      end
    end
  endtask

  task automatic test_off_after_hold();
    exp_t e;
    int t;
    start();
    for (int c = 0; c < 70; c++) begin
      t = c + 1;
      exp_q.push_back(mk(t >= 6 && t <= 35, t >= 6 && t <= 65, t == 6 || t == 36, 1'b0));
      drive(c == 5, c == 10);
      e = exp_q.pop_front();
      vectors++;
      if ({relay_out, locked, ack, fault} !== e) begin
        miscompares++;
        $display("FAIL off_after_hold cyc %0d: got %b need %b", t, {relay_out, locked, ack, fault}, e);
      end
    end
  endtask

  task automatic test_reversal();
    exp_t e;
    int t;
    start();
    for (int c = 0; c < 45; c++) begin
      t = c + 1;
      exp_q.push_back(mk(t >= 6, t >= 6 && t <= 35, t == 6, 1'b0));
      drive(c == 5 || c == 12, c == 10);
      e = exp_q.pop_front();
      vectors++;
      if ({relay_out, locked, ack, fault} !== e) begin
        miscompares++;
        $display("FAIL reversal cyc %0d: got %b need %b", t, {relay_out, locked, ack, fault}, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    int t;
    start();
    for (int c = 0; c < 15; c++) begin
      t = c + 1;
      exp_q.push_back(mk(0, 0, 0, 0));
      drive(c == 5, c == 5 || c == 8);
      e = exp_q.pop_front();
      vectors++;
      if ({relay_out, locked, ack, fault} !== e) begin
        miscompares++;
        $display("FAIL simultaneous cyc %0d: got %b need %b", t, {relay_out, locked, ack, fault}, e);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    exp_t e;
    int t;
    start();
    for (int c = 0; c < 20; c++) begin
      t = c + 1;
      exp_q.push_back(mk(t >= 6, t >= 6, t == 6, 1'b0));
      drive(c == 5, 1'b0);
      e = exp_q.pop_front();
      vectors++;
      if ({relay_out, locked, ack, fault} !== e) begin
        miscompares++;
        $display("FAIL reset_mid_hold cyc %0d: got %b need %b", t, {relay_out, locked, ack, fault}, e);
      end
    end
    // Mid-cycle 20, inside the on-hold: outputs must clear without a clock edge.
    reset = 1'b1;
    #2;
    e = mk(0, 0, 0, 0);
    vectors++;
    if ({relay_out, locked, ack, fault} !== e) begin
      miscompares++;
      $display("FAIL reset_immediate: got %b need %b", {relay_out, locked, ack, fault}, e);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    // on_req in the very first cycle after release is accepted.
    for (int c = 0; c < 5; c++) begin
      t = c + 1;
      exp_q.push_back(mk(1, 1, t == 1, 0));
      drive(c == 0, 1'b0);
      e = exp_q.pop_front();
      vectors++;
      if ({relay_out, locked, ack, fault} !== e) begin
        miscompares++;
        $display("FAIL post_reset_on cyc %0d: got %b need %b", t, {relay_out, locked, ack, fault}, e);
      end
    end
  endtask

  // Requests in stable states, a request during the off-hold, and holds
  // chained back to back at expiry.
  task automatic test_back_to_back();
    exp_t e;
    int t;
    bit r, l, a;
    start();
    for (int c = 0; c < 80; c++) begin
      t = c + 1;
      r = (t >= 1 && t <= 45) || t >= 76;
      l = (t >= 1 && t <= 30) || t >= 46;
      a = (t == 1) || (t == 46) || (t == 76);
      exp_q.push_back(mk(r, l, a, 1'b0));
      drive(c == 0 || c == 40 || c == 50, c == 45);
      e = exp_q.pop_front();
      vectors++;
      if ({relay_out, locked, ack, fault} !== e) begin
        miscompares++;
        $display("FAIL back_to_back cyc %0d: got %b need %b", t, {relay_out, locked, ack, fault}, e);
      end
    end
  endtask

  task automatic test_max_on();
    exp_t e;
    int t;
    bit r, l, a, f;
    start();
    for (int c = 0; c < 145; c++) begin
      t = c + 1;
      if (WDOG) begin
        r = (t >= 6 && t <= 105) || t >= 141;
        l = (t >= 6 && t <= 35) || (t >= 106 && t <= 135) || t >= 141;
        a = (t == 6) || (t == 106) || (t == 141);
        f = (t >= 106);
      end else begin
        r = (t >= 6);
        l = (t >= 6 && t <= 35);
        a = (t == 6);
        f = 1'b0;
      end
      exp_q.push_back(mk(r, l, a, f));
      drive(c == 5 || c == 140, 1'b0);
      e = exp_q.pop_front();
      vectors++;
      if ({relay_out, locked, ack, fault} !== e) begin
        miscompares++;
        $display("FAIL max_on cyc %0d: got %b need %b", t, {relay_out, locked, ack, fault}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_on_hold();
    test_off_after_hold();
    test_reversal();
    test_simultaneous();
    test_reset_mid_hold();
    test_back_to_back();
    test_max_on();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
